// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, divider depth.
package mdu_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5,
        OpMfhi  = 3'd6,
        OpMflo  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StWb   = 2'd3
    } state_e;

    localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
module mdu_divider
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LastIter = 5'(DIV_ITERS - 1);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [32:0] shifted;
    logic [32:0] diff;

    // Quotient register doubles as the dividend shift register.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (abort) begin
            run_d = 1'b0;
        end else if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LastIter) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done      = run_q && (cnt_q == LastIter);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: runs MULT/DIV, drives HI/LO block controls, stalls the pipe while busy.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hilo_en,
    output logic        hilo_write,
    output logic        hilo_toreg,
    output logic        hilo_src,
    output logic [31:0] hilo_in,
    output logic [63:0] mdu_result
);

    localparam logic [3:0] MulLast = 4'(MUL_LAT - 1);

    state_e             state_q, state_d;
    logic [3:0]         mul_cnt_q, mul_cnt_d;
    logic signed [63:0] mul_a_q, mul_b_q;
    logic [63:0]        mul_pipe_q [MUL_LAT];
    logic               is_div_q, neg_quo_q, neg_rem_q, div_zero_q;
    logic [31:0]        rs_q;

    op_e         op_in;
    logic        accept, is_mul_op, is_div_op, signed_op;
    logic [31:0] dividend_mag, divisor_mag;
    logic        div_done;
    logic [31:0] div_quo, div_rem, quo_fix, rem_fix;
    logic [63:0] div_result, wb_result;

    assign op_in     = op_e'(op);
    assign accept    = op_valid && !flush && (state_q == StIdle);
    assign is_mul_op = (op_in == OpMult) || (op_in == OpMultu);
    assign is_div_op = (op_in == OpDiv) || (op_in == OpDivu);
    assign signed_op = (op_in == OpMult) || (op_in == OpDiv);

    assign dividend_mag = (op_in == OpDiv && rs_val[31]) ? -rs_val : rs_val;
    assign divisor_mag  = (op_in == OpDiv && rt_val[31]) ? -rt_val : rt_val;

    mdu_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div_op),
        .abort     (flush),
        .dividend  (dividend_mag),
        .divisor   (divisor_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            is_div_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rs_q       <= '0;
        end else if (accept && (is_mul_op || is_div_op)) begin
            mul_a_q    <= {{32{signed_op & rs_val[31]}}, rs_val};
            mul_b_q    <= {{32{signed_op & rt_val[31]}}, rt_val};
            is_div_q   <= is_div_op;
            neg_quo_q  <= (op_in == OpDiv) && (rs_val[31] ^ rt_val[31]);
            neg_rem_q  <= (op_in == OpDiv) && rs_val[31];
            div_zero_q <= (rt_val == 32'd0);
            rs_q       <= rs_val;
        end
    end

    // Free-running pipeline; operands stay latched so the last stage is stable by WB.
    always_ff @(posedge clk) begin
        mul_pipe_q[0] <= mul_a_q * mul_b_q;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            mul_pipe_q[i] <= mul_pipe_q[i-1];
        end
    end

    assign quo_fix    = neg_quo_q ? -div_quo : div_quo;
    assign rem_fix    = neg_rem_q ? -div_rem : div_rem;
    assign div_result = div_zero_q ? {rs_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
    assign wb_result  = is_div_q ? div_result : mul_pipe_q[MUL_LAT-1];

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        hilo_en    = 1'b0;
        hilo_write = 1'b0;
        hilo_toreg = 1'b0;
        hilo_src   = 1'b0;
        hilo_in    = '0;
        mdu_result = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op_in)
                        OpMult, OpMultu: begin
                            state_d   = StMul;
                            mul_cnt_d = '0;
                        end
                        OpDiv, OpDivu: state_d = StDiv;
                        OpMthi, OpMtlo: begin
                            hilo_en    = 1'b1;
                            hilo_write = 1'b1;
                            hilo_src   = 1'b1;
                            hilo_toreg = (op_in == OpMthi);
                            hilo_in    = rs_val;
                        end
                        OpMfhi, OpMflo: begin
                            hilo_en    = 1'b1;
                            hilo_toreg = (op_in == OpMfhi);
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (mul_cnt_q == MulLast) begin
                    state_d = StWb;
                end else begin
                    mul_cnt_d = mul_cnt_q + 4'd1;
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (div_done) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                state_d    = StIdle;
                mdu_result = wb_result;
                if (!flush) begin
                    hilo_en    = 1'b1;
                    hilo_write = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign stall = op_valid && (state_q != StIdle) && !flush;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected results queued at issue, popped at the WB write.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int unsigned MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, op_valid, flush;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        stall, busy, hilo_en, hilo_write, hilo_toreg, hilo_src;
    logic [31:0] hilo_in;
    logic [63:0] mdu_result;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q [$];

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .hilo_en    (hilo_en),
        .hilo_write (hilo_write),
        .hilo_toreg (hilo_toreg),
        .hilo_src   (hilo_src),
        .hilo_in    (hilo_in),
        .mdu_result (mdu_result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OpMult:  r = 64'(sa * sb);
            OpMultu: r = {32'd0, a} * {32'd0, b};
            OpDiv:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OpDivu:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Wait (bounded) for the WB write; returns the cycle number after acceptance.
    task automatic wait_wb(input string tag, output int wb_cycle);
        wb_cycle = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (hilo_write === 1'b1) begin
                wb_cycle = k;
                break;
            end
            tick();
        end
        if (wb_cycle < 0) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
        else check_eq({tag, "_result"}, mdu_result, exp_q.pop_front());
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        int wb_cycle;
        int exp_lat;
        exp_lat = (o == OpMult || o == OpMultu) ? int'(MUL_LAT) + 1 : 33;
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        check_eq({tag, "_acc_stall"}, {63'd0, stall}, 64'd0);
        exp_q.push_back(exp);
        tick();
        op_valid = 1'b0;
        wait_wb(tag, wb_cycle);
        if (wb_cycle > 0) begin
            check_eq({tag, "_lat"}, 64'(wb_cycle), 64'(exp_lat));
            check_eq({tag, "_ctl"}, {61'd0, hilo_en, hilo_src, hilo_toreg}, 64'b100);
            pop_check(tag);
        end
        tick();
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  o;
        logic        wrote;
        int          wb_cycle;

        rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_busy_stall", {62'd0, busy, stall}, 64'd0);
        check_eq("rst_ctl", {60'd0, hilo_en, hilo_write, hilo_toreg, hilo_src}, 64'd0);
        check_eq("rst_in", {32'd0, hilo_in}, 64'd0);
        check_eq("rst_result", mdu_result, 64'd0);
        tick();
        rst = 1'b0;

        run_op(OpMult,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, "mult");
        run_op(OpMultu, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, "multu");
        run_op(OpDiv,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div");
        run_op(OpDivu,  32'd100, 32'd7, {32'd2, 32'd14}, "divu");
        run_op(OpDivu,  32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "divu_zero");
        run_op(OpDiv,   32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, "div_zero");
        run_op(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "div_ovf");
        run_op(OpDiv,   32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, "div_negdvs");

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i >= 4) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
            o = 3'(i % 4);
            run_op(o, a, b, model(o, a, b), $sformatf("rnd%0d", i));
        end

        // MULT followed immediately by MFLO: stalled through MUL and WB.
        op_valid = 1'b1; op = OpMult; rs_val = 32'd5; rt_val = 32'd6;
        exp_q.push_back(64'd30);
        tick();
        op = OpMflo;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("haz_stall_c%0d", c), {63'd0, stall}, 64'd1);
            if (c == 3) begin
                check_eq("haz_wb_write", {63'd0, hilo_write}, 64'd1);
                pop_check("haz");
            end
            tick();
        end
        @(negedge clk);
        check_eq("haz_mflo_stall", {63'd0, stall}, 64'd0);
        check_eq("haz_mflo_ctl", {61'd0, hilo_en, hilo_write, hilo_toreg}, 64'b100);
        tick();
        op_valid = 1'b0;

        // MTHI then MFHI back to back.
        op_valid = 1'b1; op = OpMthi; rs_val = 32'hDEAD_BEEF; rt_val = '0;
        @(negedge clk);
        check_eq("mthi_ctl", {60'd0, hilo_en, hilo_write, hilo_src, hilo_toreg}, 64'b1111);
        check_eq("mthi_in", {32'd0, hilo_in}, 64'h0000_0000_DEAD_BEEF);
        tick();
        op = OpMfhi; rs_val = '0;
        @(negedge clk);
        check_eq("mfhi_ctl", {60'd0, hilo_en, hilo_write, hilo_toreg, busy}, 64'b1010);
        tick();
        op = OpMtlo; rs_val = 32'h1234_5678;
        @(negedge clk);
        check_eq("mtlo_ctl", {60'd0, hilo_en, hilo_write, hilo_src, hilo_toreg}, 64'b1110);
        tick();
        op_valid = 1'b0;

        // Flush in IDLE drops the presented op.
        op_valid = 1'b1; op = OpMult; flush = 1'b1; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        check_eq("iflush_ctl", {62'd0, stall, hilo_en}, 64'd0);
        tick();
        op_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_eq("iflush_busy", {63'd0, busy}, 64'd0);
        tick();

        // DIV flushed at cycle 10: no write, back to IDLE at cycle 11.
        op_valid = 1'b1; op = OpDiv; rs_val = 32'd1000; rt_val = 32'd3;
        tick();
        op_valid = 1'b0;
        wrote = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (hilo_write) wrote = 1'b1;
            if (c == 9) check_eq("flush_busy_c9", {63'd0, busy}, 64'd1);
            tick();
        end
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_idle_c11", {63'd0, busy}, 64'd0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (hilo_write) wrote = 1'b1;
        end
        check_eq("flush_no_write", {63'd0, wrote}, 64'd0);
        tick();

        // Reset at cycle 5 of a DIVU.
        op_valid = 1'b1; op = OpDivu; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        op_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_busy", {63'd0, busy}, 64'd0);
        check_eq("mrst_ctl", {60'd0, hilo_en, hilo_write, hilo_toreg, hilo_src}, 64'd0);
        check_eq("mrst_data", mdu_result | {32'd0, hilo_in}, 64'd0);
        wrote = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (hilo_write) wrote = 1'b1;
        end
        check_eq("mrst_no_write", {63'd0, wrote}, 64'd0);
        tick();
        run_op(OpDivu, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_after_rst");

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
